fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- First pipeline stage of the five-stage RV32I core; sits directly upstream of the instruction memory and feeds decode.
- Owns the PC and issues one word-aligned read per cycle to imemory; the read data returns on the next cycle.
- Buffers returned instructions in a 2-entry queue with a valid/ready handshake to decode.
- Accepts branch/jump redirects from execute and squashes all wrong-path fetches.

Parameters:
- PC_RESET, 32'h01000000, PC after reset.
- FIFO_DEPTH, 2, instruction queue depth; fixed at 2 (minimum for full throughput with 1-cycle memory latency).

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_address  out  32  fetch address to imemory; bits [1:0] always 0.
- imem_read_write  out  32  tied to 32'h0 (read only).
- imem_data_out  out  32  tied to 32'h0 (unused write data).
- imem_data_in  in  32  imemory read data; valid the cycle after the matching address.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  new PC; bits [1:0] ignored and treated as 0.
- f_valid  out  1  f_pc/f_inst hold a valid instruction.
- f_ready  in  1  decode accepts this cycle; transfer occurs when f_valid && f_ready.
- f_pc  out  32  PC of the head instruction.
- f_inst  out  32  instruction word of the head entry.

Behaviour:
- Reset state:
  - pc_q = PC_RESET, queue empty, inflight_q = 0.
  - f_valid = 0; f_pc = PC_RESET; f_inst = 32'h00000013 (NOP).
  - imem_address = PC_RESET.
- imem_address is combinational: redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q.
- Memory contract: address presented in cycle t produces data on imem_data_in in cycle t+1.
- pop = f_valid && f_ready && !redirect_valid.
- Issue condition: issue = (count + inflight_q - pop) < FIFO_DEPTH, or redirect_valid.
  - On issue: inflight_q <= 1, req_pc_q <= imem_address, pc_q <= imem_address + 4 (mod 2^32; 0xFFFFFFFC wraps to 0).
  - No issue: inflight_q <= 0, pc_q unchanged.
- Response capture: if inflight_q && !redirect_valid, push {req_pc_q, imem_data_in} at the queue tail in the same cycle.
- Simultaneous push and pop: count unchanged, order preserved.
- Queue never overflows; the issue rule guarantees this. Assertion: push while count == FIFO_DEPTH && !pop is an error.
- Redirect cycle:
  - Queue flushed (count <= 0).
  - Response arriving this cycle is dropped.
  - f_valid is forced to 0 combinationally and any handshake in this cycle is void.
  - A new request at redirect_pc is issued the same cycle; first redirected instruction reaches f_valid 2 cycles after redirect_valid is sampled.
- Back-to-back redirects: the last one wins; each squashes the previous one's in-flight request.
- Outputs:
  - f_valid = (count != 0) && !redirect_valid.
  - f_pc/f_inst are the head entry; they hold stable while f_valid && !f_ready.
  - When the queue is empty they show the last popped entry (don't-care to decode).
- Steady state with f_ready = 1: one instruction per cycle, PCs ascending by 4, no bubbles after the initial 2-cycle fill.
- Reset asserted mid-operation: queue, inflight and PC return to reset values immediately; the data returned after reset deasserts is ignored because inflight_q = 0.

Decomposition:
- Package core_pkg:
  - PC_RESET, XLEN = 32, INST_NOP = 32'h00000013.
  - fetch_entry_t {pc[31:0], inst[31:0]}.
- Sub-module fetch_queue: 2-entry synchronous FIFO with push, pop, flush, count, and head output.
  - Flush has priority over push.
- fetch_stage holds the PC, inflight tracking and issue logic, and instantiates fetch_queue.

Test Plan:
- Reset release, f_ready = 1, memory returns word = address: f_valid first high in cycle 2 with f_pc = 0x01000000, f_inst = 0x01000000; then 0x01000004, 0x01000008 on consecutive cycles.
- Hold f_ready = 0 for 5 cycles after the first valid: f_pc stays 0x01000000, imem_address stops advancing after 2 outstanding entries; release gives 0x01000000, 0x01000004, 0x01000008 with no gap and no duplicates.
- Redirect to 0x01000103 while streaming: imem_address = 0x01000100 the same cycle; f_valid = 0 for 2 cycles; next f_pc = 0x01000100; stale 0x0100000C never delivered.
- Redirect with queue full and f_ready = 0: queue flushed, next delivered f_pc = redirect target; two redirects on consecutive cycles (0x200, then 0x300): only 0x300 stream is delivered.
- pc_q = 0xFFFFFFF8, f_ready = 1: delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert reset for 1 cycle mid-stream with 2 entries queued: f_valid = 0 immediately (asynchronous); after release the stream restarts at 0x01000000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] PC_RESET = 32'h0100_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;   // addi x0, x0, 0

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue between the fetch PC logic and decode.
// Entry 0 is always the head, so the head output is a plain register and,
// once the queue drains, it keeps showing the most recently popped entry.
module fetch_queue
    import core_pkg::*;
#(
    parameter int           DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '{pc: PC_RESET, inst: INST_NOP}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [1:0]               count_q, count_d;
    logic                     pop_eff;
    logic                     push_eff;

    // A pop on an empty queue or a push into a full one (without a matching
    // pop) is ignored so the head entry can never be corrupted.
    assign pop_eff  = pop_i && (count_q != 2'd0);
    assign push_eff = push_i && ((count_q != 2'(DEPTH)) || pop_eff);

    // Next-state: flush wins over everything, otherwise shift on pop and
    // write the new entry into the first free slot after the shift.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    entry_d[count_q[0]] = push_entry_i;
                    count_d             = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        entry_d[0] = entry_q[1];
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        entry_d[0] = entry_q[1];
                        entry_d[1] = push_entry_i;
                    end else begin
                        entry_d[0] = push_entry_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= {DEPTH{RESET_ENTRY}};
            count_q <= 2'd0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[0];

    // The issue logic upstream must never let the queue overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == 2'(DEPTH)) && !pop_i));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues one aligned read per cycle to instruction
// memory (1-cycle latency), buffers returns in a 2-entry queue and hands them
// to decode with valid/ready. Redirects from execute squash wrong-path work.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = core_pkg::PC_RESET,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic [31:0] imem_read_write,
    output logic [31:0] imem_data_out,
    input  logic [31:0] imem_data_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_pc,
    output logic [31:0] f_inst
);

    localparam fetch_entry_t QUEUE_RESET_ENTRY = '{pc: PC_RESET, inst: INST_NOP};

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         inflight_q, inflight_d;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   occupancy;

    // Memory port is read-only.
    assign imem_read_write = 32'h0;
    assign imem_data_out   = 32'h0;

    // A redirect takes the memory port in the same cycle it is requested.
    assign imem_address = redirect_valid ? word_align(redirect_pc) : pc_q;

    // Decode sees nothing during a redirect cycle; any handshake is void.
    assign f_valid = (count != 2'd0) && !redirect_valid;
    assign pop     = f_valid && f_ready;

    // Entries that will exist once this cycle's pop and pending return settle;
    // only issue if the returning word is guaranteed a slot.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = redirect_valid || (occupancy < 3'(FIFO_DEPTH));

    // Returning data is wrong-path if a redirect is happening now.
    assign push       = inflight_q && !redirect_valid;
    assign push_entry = '{pc: req_pc_q, inst: imem_data_in};

    // PC advance and request tracking for the next cycle.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (issue) begin
            req_pc_d = imem_address;
            pc_d     = imem_address + 32'd4;
        end
    end

    // PC and in-flight request registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            req_pc_q   <= PC_RESET;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH       (FIFO_DEPTH),
        .RESET_ENTRY (QUEUE_RESET_ENTRY)
    ) u_queue (
        .clk          (clock),
        .rst          (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_o       (head)
    );

    assign f_pc   = head.pc;
    assign f_inst = head.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage. The reference model only
// knows the architectural contract: the next PC decode should receive, and
// how many cycles after a reset or redirect the stream becomes valid.
module tb_fetch_stage;

    localparam logic [31:0] PC_RST = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_address;
    logic [31:0] imem_read_write;
    logic [31:0] imem_data_out;
    logic [31:0] imem_data_in = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_pc;
    logic [31:0] f_inst;

    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    logic [31:0] next_exp;      // PC decode must receive next
    int          age;           // cycles since the first request after reset/redirect
    logic [31:0] mem_key = 32'h0;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_read_write (imem_read_write),
        .imem_data_out   (imem_data_out),
        .imem_data_in    (imem_data_in),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .f_valid         (f_valid),
        .f_ready         (f_ready),
        .f_pc            (f_pc),
        .f_inst          (f_inst)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ mem_key;
    endfunction

    // Instruction memory: data for the address seen this cycle appears next cycle.
    always @(posedge clock) imem_data_in <= mem_word(imem_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check outputs,
    // advance the model, then move to the next falling edge.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        f_ready        = rdy;
        #1;
        check("f_valid", {31'b0, f_valid}, {31'b0, (!rv && age >= 2)});
        check("imem_align", {30'b0, imem_address[1:0]}, 32'h0);
        check("imem_ro", imem_read_write | imem_data_out, 32'h0);
        if (rv) check("imem_redirect", imem_address, rpc & 32'hFFFF_FFFC);
        if (f_valid && !rv) begin
            check("f_pc", f_pc, next_exp);
            check("f_inst", f_inst, mem_word(next_exp));
            $display("xfer pc=%h inst=%h ready=%0d", f_pc, f_inst, rdy);
            if (rdy) next_exp = next_exp + 32'd4;
        end
        if (rv) begin
            next_exp = rpc & 32'hFFFF_FFFC;
            age      = 1;
        end else if (age < 2) begin
            age++;
        end
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_f_valid"}, {31'b0, f_valid}, 32'h0);
        check({tag, "_f_pc"}, f_pc, PC_RST);
        check({tag, "_f_inst"}, f_inst, NOP);
        check({tag, "_imem_addr"}, imem_address, PC_RST);
    endtask

    initial begin
        // Reset and release between clock edges
        repeat (2) @(negedge clock);
        reset = 1'b0;
        age      = 0;
        next_exp = PC_RST;
        #1;
        check_reset_outputs("reset");

        // Streaming fill: first valid in cycle 2, then one per cycle
        repeat (6) cycle(1'b0, 32'h0, 1'b1);

        // Decode stall: two entries outstanding, fetch address holds
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            check("stall_imem_hold", imem_address, next_exp + 32'd8);
        end
        repeat (5) cycle(1'b0, 32'h0, 1'b1);

        // Redirect while streaming, unaligned target
        cycle(1'b1, 32'h0100_0103, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);

        // Redirect with queue full and decode stalled
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0200_0000, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: last one wins
        cycle(1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-stream with the queue full
        repeat (2) cycle(1'b0, 32'h0, 1'b0);
        reset   = 1'b1;
        mem_key = 32'h5A5A_F00F;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        age      = 0;
        next_exp = PC_RST;
        repeat (6) cycle(1'b0, 32'h0, 1'b1);

        // Randomized redirects and decode back-pressure
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
